// File: rtl/frame_sync_pkg.sv
// frame_sync_pkg: shared types and helpers for the parametrised frame synchronizer.
//   state_e   : FSM state codes (3-bit), also driven out on synchronizer_state.
//   popcount  : number of set bits in a 32-bit vector.
//   cnt_width : counter width able to hold values 0..n-1 (minimum 1 bit).
// Optional feature macro used by the files importing this package: INVERTED_SYNC_EN.
package frame_sync_pkg;

  typedef enum logic [2:0] {
    StHunt     = 3'd0,
    StCheck    = 3'd1,
    StLocked   = 3'd2,
    StFlywheel = 3'd3
  } state_e;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_word_correlator.sv
// sync_word_correlator: serial shift register plus Hamming-distance comparators
// against the sync word.
// Ports:
//   clk_out        in  bit clock
//   rst            in  synchronous active-low reset
//   data_in        in  serial bit, MSB first
//   data_in_valid  in  shift enable
//   inv_pol        in  (INVERTED_SYNC_EN only) selects inverted word for lock_match
//   hunt_match_inv out (INVERTED_SYNC_EN only) inverted word within HUNT_ERR
//   hunt_match     out true word within HUNT_ERR
//   lock_match     out selected-polarity word within LOCK_ERR
// All matches are combinational and evaluated on the window including the current
// data_in, so the caller must qualify them with data_in_valid.
// Macro: INVERTED_SYNC_EN adds inverted-polarity recognition.
module sync_word_correlator
  import frame_sync_pkg::*;
#(
  parameter int unsigned          SYNC_LEN  = 8,
  parameter logic [SYNC_LEN-1:0]  SYNC_WORD = 8'hE2,
  parameter int unsigned          HUNT_ERR  = 0,
  parameter int unsigned          LOCK_ERR  = 1
) (
  input  logic clk_out,
  input  logic rst,
  input  logic data_in,
  input  logic data_in_valid,
`ifdef INVERTED_SYNC_EN
  input  logic inv_pol,
  output logic hunt_match_inv,
`endif
  output logic hunt_match,
  output logic lock_match
);

  // Only SYNC_LEN-1 history bits are stored; the newest bit is data_in itself.
  logic [SYNC_LEN-2:0] sr_q;
  logic [SYNC_LEN-1:0] next_sr;
  int unsigned         dist_true;

  assign next_sr = {sr_q, data_in};

  always_ff @(posedge clk_out) begin
    if (!rst) begin
      sr_q <= '0;
    end else if (data_in_valid) begin
      sr_q <= next_sr[SYNC_LEN-2:0];
    end
  end

  always_comb begin
    dist_true  = popcount(32'(next_sr ^ SYNC_WORD));
    hunt_match = (dist_true <= HUNT_ERR);
  end

`ifdef INVERTED_SYNC_EN
  int unsigned dist_inv;

  always_comb begin
    dist_inv       = popcount(32'(next_sr ^ ~SYNC_WORD));
    hunt_match_inv = (dist_inv <= HUNT_ERR);
    lock_match     = ((inv_pol ? dist_inv : dist_true) <= LOCK_ERR);
  end
`else
  always_comb begin
    lock_match = (dist_true <= LOCK_ERR);
  end
`endif

endmodule

// File: rtl/frame_sync_param.sv
// frame_sync_param: serial frame synchronizer with error-tolerant sync-word search,
// multi-frame lock confirmation, flywheeling through missed headers and aligned
// payload output.
// Frame layout on the wire: SYNC_LEN-bit header followed by PAYLOAD_LEN payload bits.
// Ports:
//   clk_out              in  bit clock
//   rst                  in  synchronous active-low reset
//   data_in              in  serial bit, MSB first
//   data_in_valid        in  data_in qualifier; nothing advances while low
//   is_frame_sychronized out high in LOCKED or FLYWHEEL
//   synchronizer_state   out 0=HUNT 1=CHECK 2=LOCKED 3=FLYWHEEL
//   data_sync_out        out registered payload bit
//   data_sync_valid      out data_sync_out qualifier
//   frame_start          out pulses with the first payload bit of each frame
//   sync_loss_cnt        out saturating count of lock losses
// Macro: INVERTED_SYNC_EN also accepts the inverted sync word and un-inverts payload.
module frame_sync_param
  import frame_sync_pkg::*;
#(
  parameter int unsigned          SYNC_LEN    = 8,
  parameter logic [SYNC_LEN-1:0]  SYNC_WORD   = 8'hE2,
  parameter int unsigned          PAYLOAD_LEN = 32,
  parameter int unsigned          HUNT_ERR    = 0,
  parameter int unsigned          LOCK_ERR    = 1,
  parameter int unsigned          CONFIRM_CNT = 2,
  parameter int unsigned          LOSS_CNT    = 3
) (
  input  logic       clk_out,
  input  logic       rst,
  input  logic       data_in,
  input  logic       data_in_valid,
  output logic       is_frame_sychronized,
  output logic [2:0] synchronizer_state,
  output logic       data_sync_out,
  output logic       data_sync_valid,
  output logic       frame_start,
  output logic [7:0] sync_loss_cnt
);

  localparam int unsigned FrameLen = PAYLOAD_LEN + SYNC_LEN;
  localparam int unsigned Cw       = cnt_width(FrameLen);
  localparam int unsigned Hw       = cnt_width(CONFIRM_CNT + 1);
  localparam int unsigned Mw       = cnt_width(LOSS_CNT + 1);

  state_e          state_q, state_d;
  logic [Cw-1:0]   bit_cnt_q, bit_cnt_d;
  logic [Hw-1:0]   hit_cnt_q, hit_cnt_d;
  logic [Mw-1:0]   miss_cnt_q, miss_cnt_d;
  logic [7:0]      loss_q, loss_d;
  logic            dso_q, dso_d;
  logic            dsv_q, dsv_d;
  logic            fs_q, fs_d;
  logic            inv;

  logic            hunt_match, lock_match, hunt_any;
  logic            hdr_slot, payload_slot, locked_any, emit;
  logic            go_hunt, loss_inc;

`ifdef INVERTED_SYNC_EN
  logic            inv_pol_q, inv_pol_d;
  logic            hunt_match_inv;

  assign hunt_any = hunt_match | hunt_match_inv;
  assign inv      = inv_pol_q;
`else
  assign hunt_any = hunt_match;
  assign inv      = 1'b0;
`endif

  sync_word_correlator #(
    .SYNC_LEN  (SYNC_LEN),
    .SYNC_WORD (SYNC_WORD),
    .HUNT_ERR  (HUNT_ERR),
    .LOCK_ERR  (LOCK_ERR)
  ) u_corr (
    .clk_out        (clk_out),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
`ifdef INVERTED_SYNC_EN
    .inv_pol        (inv_pol_q),
    .hunt_match_inv (hunt_match_inv),
`endif
    .hunt_match     (hunt_match),
    .lock_match     (lock_match)
  );

  assign hdr_slot     = (bit_cnt_q == Cw'(FrameLen - 1));
  assign payload_slot = (bit_cnt_q < Cw'(PAYLOAD_LEN));
  assign locked_any   = (state_q == StLocked) || (state_q == StFlywheel);
  assign emit         = data_in_valid && payload_slot && locked_any;

  // Next-state logic; everything is frozen while data_in_valid is low.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    loss_d     = loss_q;
    go_hunt    = 1'b0;
    loss_inc   = 1'b0;
`ifdef INVERTED_SYNC_EN
    inv_pol_d  = inv_pol_q;
`endif
    if (data_in_valid) begin
      bit_cnt_d = hdr_slot ? '0 : bit_cnt_q + Cw'(1);
      case (state_q)
        StHunt: begin
          if (hunt_any) begin
            // Header just completed: next bit is payload slot 0.
            bit_cnt_d = '0;
            hit_cnt_d = Hw'(1);
            state_d   = (CONFIRM_CNT == 1) ? StLocked : StCheck;
`ifdef INVERTED_SYNC_EN
            inv_pol_d = ~hunt_match;
`endif
          end
        end
        StCheck: begin
          if (hdr_slot) begin
            if (lock_match) begin
              hit_cnt_d = hit_cnt_q + Hw'(1);
              if (hit_cnt_d == Hw'(CONFIRM_CNT)) begin
                state_d = StLocked;
              end
            end else begin
              go_hunt = 1'b1;
            end
          end
        end
        StLocked: begin
          if (hdr_slot && !lock_match) begin
            if (LOSS_CNT == 1) begin
              go_hunt  = 1'b1;
              loss_inc = 1'b1;
            end else begin
              state_d    = StFlywheel;
              miss_cnt_d = Mw'(1);
            end
          end
        end
        StFlywheel: begin
          if (hdr_slot) begin
            if (lock_match) begin
              state_d    = StLocked;
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + Mw'(1);
              if (miss_cnt_d == Mw'(LOSS_CNT)) begin
                go_hunt  = 1'b1;
                loss_inc = 1'b1;
              end
            end
          end
        end
        default: go_hunt = 1'b1;
      endcase
      if (go_hunt) begin
        state_d    = StHunt;
        hit_cnt_d  = '0;
        miss_cnt_d = '0;
`ifdef INVERTED_SYNC_EN
        inv_pol_d  = 1'b0;
`endif
      end
      if (loss_inc && (loss_q != 8'hFF)) begin
        loss_d = loss_q + 8'd1;
      end
    end
  end

  // Payload outputs are decided by the pre-transition state, so a header-slot
  // transition affects the following bit.
  always_comb begin
    dsv_d = emit;
    fs_d  = emit && (bit_cnt_q == '0);
    dso_d = emit ? (data_in ^ inv) : dso_q;
  end

  always_ff @(posedge clk_out) begin
    if (!rst) begin
      state_q    <= StHunt;
      bit_cnt_q  <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      loss_q     <= '0;
      dso_q      <= 1'b0;
      dsv_q      <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      loss_q     <= loss_d;
      dso_q      <= dso_d;
      dsv_q      <= dsv_d;
      fs_q       <= fs_d;
    end
  end

`ifdef INVERTED_SYNC_EN
  always_ff @(posedge clk_out) begin
    if (!rst) begin
      inv_pol_q <= 1'b0;
    end else begin
      inv_pol_q <= inv_pol_d;
    end
  end
`endif

  assign is_frame_sychronized = locked_any;
  assign synchronizer_state   = state_q;
  assign data_sync_out        = dso_q;
  assign data_sync_valid      = dsv_q;
  assign frame_start          = fs_q;
  assign sync_loss_cnt        = loss_q;

endmodule

// File: doc/frame_sync_param.md
Name: frame_sync_param

Overview:
- Parametrised successor to the serial frame synchronizer that sits between the Hamming encoder output and the decoder.
- Searches a serial bit stream for a configurable sync word, with a tolerated bit-error count.
- Confirms lock over several frames, flywheels through missed headers, and emits aligned payload bits with a frame-start strobe.
- One instance per serial channel, all on the fast (bit) clock domain.

Parameters:
- SYNC_LEN, 8: sync-word length in bits (2..32).
- SYNC_WORD, 8'hE2: sync pattern. Sent MSB first; width SYNC_LEN.
- PAYLOAD_LEN, 32: payload bits between consecutive sync words (>=1).
- HUNT_ERR, 0: max Hamming distance accepted while in HUNT.
- LOCK_ERR, 1: max Hamming distance accepted at expected header slots (CHECK, LOCKED, FLYWHEEL).
- CONFIRM_CNT, 2: consecutive header hits needed to reach LOCKED (>=1). The HUNT hit counts as the first.
- LOSS_CNT, 3: consecutive header misses that drop lock (>=1).

Ports:
- clk_out, in, 1: bit clock.
- rst, in, 1: synchronous, active-low reset.
- data_in, in, 1: serial bit, MSB first.
- data_in_valid, in, 1: data_in qualifier. Nothing advances while low.
- is_frame_sychronized, out, 1: high in LOCKED or FLYWHEEL.
- synchronizer_state, out, 3: 0=HUNT, 1=CHECK, 2=LOCKED, 3=FLYWHEEL.
- data_sync_out, out, 1: payload bit, registered.
- data_sync_valid, out, 1: data_sync_out qualifier.
- frame_start, out, 1: pulses with the first payload bit of each frame.
- sync_loss_cnt, out, 8: saturating count of lock losses.

Behaviour:
- Reset (rst==0 at a clk_out edge):
  - state=HUNT; shift register, bit_cnt, hit_cnt, miss_cnt cleared.
  - All outputs 0; sync_loss_cnt=0.
  - Reset applied mid-frame or mid-lock aborts immediately. There is no partial-state retention.
- Shifting: on each valid bit, sr <= {sr[SYNC_LEN-2:0], data_in}. dist = popcount(next_sr ^ SYNC_WORD), evaluated on the shifted-in value.
- Frame counter: bit_cnt runs 0..PAYLOAD_LEN+SYNC_LEN-1 on valid bits. Payload slots are bit_cnt<PAYLOAD_LEN. The header check fires at bit_cnt==PAYLOAD_LEN+SYNC_LEN-1, after which bit_cnt wraps to 0.
- HUNT: checks every valid bit. If dist<=HUNT_ERR:
  - bit_cnt=0, hit_cnt=1.
  - Go to CHECK, or straight to LOCKED if CONFIRM_CNT==1.
- CHECK, at each header slot:
  - dist<=LOCK_ERR: hit_cnt++. When hit_cnt reaches CONFIRM_CNT, go to LOCKED.
  - Otherwise go to HUNT, with hit_cnt=0 and sr retained.
- LOCKED, at each header slot:
  - Miss: go to FLYWHEEL, miss_cnt=1. If LOSS_CNT==1, go directly to HUNT.
  - Hit: stay in LOCKED.
- FLYWHEEL, at each header slot:
  - Hit: go to LOCKED, miss_cnt=0.
  - Miss: miss_cnt++. When it reaches LOSS_CNT, go to HUNT and increment sync_loss_cnt, saturating at 255.
- Payload output (1-cycle latency):
  - data_sync_out <= data_in.
  - data_sync_valid <= data_in_valid && bit_cnt<PAYLOAD_LEN && state in {LOCKED, FLYWHEEL}.
  - frame_start <= same condition && bit_cnt==0.
  - In HUNT and CHECK, data_sync_valid=0 and data_sync_out holds its last value.
- Transition timing: a transition into LOCKED on a header slot makes the very next payload bit valid. A transition into HUNT suppresses valid from the next bit onward.
- Sync word emulated inside payload: ignored when not in HUNT, because only header slots are checked.
- Gaps: data_in_valid low for any length freezes bit_cnt, sr and state. No timeout.

Optional Feature:
- INVERTED_SYNC_EN.
- When defined:
  - HUNT also accepts popcount(next_sr ^ ~SYNC_WORD)<=HUNT_ERR. A match on the inverted word latches inv_pol=1.
  - Later header checks use the word matching inv_pol.
  - data_sync_out = data_in ^ inv_pol.
  - inv_pol clears on reset and on entry to HUNT.
- When undefined: only true polarity is recognised; no inv_pol logic exists.

Decomposition:
- Package frame_sync_pkg holds:
  - state typedef/localparams (HUNT, CHECK, LOCKED, FLYWHEEL as 3-bit codes).
  - popcount function.
  - counter-width helper (clog2 of PAYLOAD_LEN+SYNC_LEN).
- Sub-module sync_word_correlator contains the shift register, the XOR/popcount, and the hunt-match and lock-match comparators (plus the inverted match when INVERTED_SYNC_EN is defined). It is parametrised by SYNC_LEN, SYNC_WORD, HUNT_ERR and LOCK_ERR.
- The top level holds the FSM, bit_cnt and output registers.

Test Plan:
- Acquisition: defaults; 5 frames of 8'hE2 + 32 random bits.
  - State goes 0→1 after the first header, then 1→2 after the second.
  - data_sync_valid high for exactly 32 bits per frame from frame 2's payload on.
  - frame_start pulses once per frame, 1 cycle after the first payload bit enters.
- Tolerance: locked stream with 1 bit flipped in a header → stays in LOCKED. With 2 bits flipped → FLYWHEEL, miss_cnt=1. A clean header next → LOCKED.
- Loss: locked, then 3 consecutive corrupted headers → HUNT, data_sync_valid=0 from the next bit, sync_loss_cnt=1.
- False sync: 8'hE2 embedded in payload while in CHECK → no effect. Random stream containing one isolated 8'hE2 → HUNT→CHECK, then back to HUNT at the mismatched expected header.
- Stalls and reset: data_in_valid toggled 50% during lock → outputs identical to the unstalled run apart from timing. rst=0 for one cycle mid-payload → all outputs 0, state 0 next cycle.
- INVERTED_SYNC_EN: send 8'h1D headers and an inverted payload → lock achieved and data_sync_out equals the original, non-inverted payload.
